// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port request/grant arbiter in front of the single-port data
// memory. Port 0 is the CPU load/store path, port 1 the host/debug port.
// Each access runs IDLE -> ISSUE (memory samples the op) -> RESP (reads only),
// so at most one access is in flight and the memory sees exactly one op per grant.
module dmem_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PRIO_FIXED = (FIXED_PRIO != 32'sd0);

  state_t state_r;
  logic   owner_r;       // port whose access is in flight
  logic   last_owner_r;  // port served most recently; the other one wins a tie
  logic   any_req_s;
  logic   win_s;         // 0 = port 0, 1 = port 1

  // Choose which port would start an access if the arbiter is idle this cycle.
  always_comb begin
    any_req_s = req0 | req1;
    win_s     = 1'b0;
    if (req0 && req1) begin
      if (PRIO_FIXED) begin
        win_s = 1'b0;
      end else begin
        win_s = ~last_owner_r;
      end
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Access sequencer: latch the winner's op, issue it to memory, return read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= {DATA_W{1'b0}};
      rdata1       <= {DATA_W{1'b0}};
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_din      <= {DATA_W{1'b0}};
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (any_req_s) begin
            mem_addr     <= win_s ? addr1  : addr0;
            mem_din      <= win_s ? wdata1 : wdata0;
            mem_we       <= win_s ? we1    : we0;
            gnt0         <= ~win_s;
            gnt1         <= win_s;
            owner_r      <= win_s;
            last_owner_r <= win_s;
            busy         <= 1'b1;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // The memory samples we/addr/d_in on this edge; address and data hold.
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= RESP;
          end
        end
        RESP: begin
          if (owner_r) begin
            rdata1  <= mem_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_dout;
            rvalid0 <= 1'b1;
          end
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a transaction-level model predicts every grant and
// read response into queues; an independent monitor pops and compares them.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;

  // Round-robin DUT signals
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [1:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [3:0] mem_addr;

  // Fixed-priority DUT signals
  logic       p_req0, p_we0, p_req1, p_we1;
  logic [3:0] p_addr0, p_addr1;
  logic [1:0] p_wdata0, p_wdata1;
  logic       p_gnt0, p_gnt1, p_rvalid0, p_rvalid1, p_mem_we, p_busy;
  logic [1:0] p_rdata0, p_rdata1, p_mem_din, p_mem_dout;
  logic [3:0] p_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(2), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(4), .DATA_W(2), .FIXED_PRIO(1)) dut_p (
    .clk(clk), .rst(rst),
    .req0(p_req0), .we0(p_we0), .addr0(p_addr0), .wdata0(p_wdata0),
    .gnt0(p_gnt0), .rdata0(p_rdata0), .rvalid0(p_rvalid0),
    .req1(p_req1), .we1(p_we1), .addr1(p_addr1), .wdata1(p_wdata1),
    .gnt1(p_gnt1), .rdata1(p_rdata1), .rvalid1(p_rvalid1),
    .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_din(p_mem_din),
    .mem_dout(p_mem_dout), .busy(p_busy)
  );

  // Single-port 16x2 memories with registered read
  logic [1:0] mem_a [16];
  logic [1:0] mem_p [16];
  always @(posedge clk) begin
    if (mem_we) mem_a[mem_addr] <= mem_din;
    mem_dout <= mem_a[mem_addr];
    if (p_mem_we) mem_p[p_mem_addr] <= p_mem_din;
    p_mem_dout <= mem_p[p_mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int cyc; int port; logic we; logic [3:0] a; logic [1:0] d; } gexp_t;
  typedef struct { int cyc; int port; logic [1:0] d; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int    gnt_log[$];

  int         cyc = 0;
  int         next_idle = 0;
  int         last_w = 1;
  logic [1:0] mem_model [16];
  bit         pend = 1'b0;
  int         pend_cyc;
  logic [3:0] pend_a;
  logic [1:0] pend_d;

  initial begin : model
    gexp_t ge;
    rexp_t re;
    int    w;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        gq.delete(); rq.delete();
        pend = 1'b0; next_idle = 0; last_w = 1;
      end else begin
        if (pend && cyc == pend_cyc) begin
          mem_model[pend_a] = pend_d;
          pend = 1'b0;
        end
        if (cyc >= next_idle && (req0 || req1)) begin
          if (req0 && req1) w = (last_w == 0) ? 1 : 0;
          else w = req1 ? 1 : 0;
          last_w  = w;
          ge.cyc  = cyc;
          ge.port = w;
          ge.we   = (w == 1) ? we1 : we0;
          ge.a    = (w == 1) ? addr1 : addr0;
          ge.d    = (w == 1) ? wdata1 : wdata0;
          gq.push_back(ge);
          if (ge.we) begin
            pend = 1'b1; pend_cyc = cyc + 1; pend_a = ge.a; pend_d = ge.d;
            next_idle = cyc + 2;
          end else begin
            re.cyc = cyc + 2; re.port = w; re.d = mem_model[ge.a];
            rq.push_back(re);
            next_idle = cyc + 3;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    gexp_t      e;
    rexp_t      r;
    logic [1:0] hold0 = 2'b00;
    logic [1:0] hold1 = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        hold0 = 2'b00; hold1 = 2'b00;
      end else begin
        check("gnt_excl", int'(gnt0 & gnt1), 0);
        check("rvalid_excl", int'(rvalid0 & rvalid1), 0);
        check("gnt_rvalid_same_port", int'((gnt0 & rvalid0) | (gnt1 & rvalid1)), 0);
        check("busy", int'(busy), (cyc < next_idle - 1) ? 1 : 0);
        if (gnt0 || gnt1) begin
          if (gq.size() == 0) check("unexpected_gnt", 1, 0);
          else begin
            e = gq.pop_front();
            check("gnt_port", gnt1 ? 1 : 0, e.port);
            check("gnt_cycle", cyc, e.cyc);
            check("mem_we", int'(mem_we), int'(e.we));
            check("mem_addr", int'(mem_addr), int'(e.a));
            check("mem_din", int'(mem_din), int'(e.d));
            gnt_log.push_back(gnt1 ? 1 : 0);
          end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          e = gq.pop_front();
          check("missing_gnt", 0, 1);
        end
        if (rvalid0 || rvalid1) begin
          if (rq.size() == 0) check("unexpected_rvalid", 1, 0);
          else begin
            r = rq.pop_front();
            check("rvalid_port", rvalid1 ? 1 : 0, r.port);
            check("rvalid_cycle", cyc, r.cyc);
            if (r.port == 0) hold0 = r.d; else hold1 = r.d;
          end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          check("missing_rvalid", 0, 1);
        end
        check("rdata0", int'(rdata0), int'(hold0));
        check("rdata1", int'(rdata1), int'(hold1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic r, input logic w,
                       input logic [3:0] a, input logic [1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Hold a request until granted n times (wd>0: withdraw after wd ungranted cycles).
  task automatic port_access(input int p, input logic we, input logic [3:0] a,
                             input logic [1:0] d, input int n, input int wd);
    int  waited;
    int  limit;
    bit  got;
    limit = (wd > 0) ? wd : 40;
    @(negedge clk);
    drive(p, 1'b1, we, a, d);
    for (int k = 0; k < n; k++) begin
      waited = 0; got = 1'b0;
      while (!got && waited < limit) begin
        @(negedge clk);
        if ((p == 0 && gnt0) || (p == 1 && gnt1)) got = 1'b1;
        else waited++;
      end
      if (!got && wd == 0) check("gnt_timeout", 0, 1);
      if (!got) break;
    end
    drive(p, 1'b0, we, a, d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, int'(gnt0), 0);
    check({tag, "_gnt1"}, int'(gnt1), 0);
    check({tag, "_rvalid0"}, int'(rvalid0), 0);
    check({tag, "_rvalid1"}, int'(rvalid1), 0);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_din"}, int'(mem_din), 0);
    check({tag, "_rdata0"}, int'(rdata0), 0);
    check({tag, "_rdata1"}, int'(rdata1), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 4'd0; wdata0 = 2'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; wdata1 = 2'd0;
    p_req0 = 1'b0; p_we0 = 1'b0; p_addr0 = 4'd1; p_wdata0 = 2'd0;
    p_req1 = 1'b0; p_we1 = 1'b0; p_addr1 = 4'd2; p_wdata1 = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst = 1'b1;

    // Write then read the same word through different ports
    port_access(0, 1'b1, 4'd3, 2'b10, 1, 0);
    port_access(1, 1'b0, 4'd3, 2'b00, 1, 0);
    repeat (3) @(negedge clk);
    check("dir_rdata1", int'(rdata1), 2);
    check("dir_rdata0_untouched", int'(rdata0), 0);

    // Fill the memory
    for (int i = 0; i < 16; i++)
      port_access(i % 2, 1'b1, 4'(i), 2'($urandom_range(0, 3)), 1, 0);

    // Reset mid-run
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check_all_zero("midrst");
    rst = 1'b1;

    // Continuous conflict: grants must alternate 0,1,0,1
    gnt_log.delete();
    fork
      port_access(0, 1'b0, 4'd1, 2'd0, 2, 0);
      port_access(1, 1'b0, 4'd2, 2'd0, 2, 0);
    join
    repeat (4) @(negedge clk);
    check("rr_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      check("rr_order0", gnt_log[0], 0);
      check("rr_order1", gnt_log[1], 1);
      check("rr_order2", gnt_log[2], 0);
      check("rr_order3", gnt_log[3], 1);
    end

    // Port 1 request withdrawn while a port 0 read is in RESP
    fork
      port_access(0, 1'b0, 4'd7, 2'd0, 1, 0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
        check("wd_saw_gnt0", (n < 20) ? 1 : 0, 1);
        @(negedge clk); req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 2'd3;
        @(negedge clk); req1 = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("wd_busy_idle", int'(busy), 0);

    // Write dropped by reset before its ISSUE edge; read aborted by reset in RESP
    port_access(0, 1'b1, 4'd9, 2'b01, 1, 0);
    port_access(0, 1'b1, 4'd9, 2'b11, 1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    port_access(0, 1'b0, 4'd9, 2'd0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    port_access(0, 1'b0, 4'd9, 2'd0, 1, 0);
    repeat (3) @(negedge clk);
    check("rst_read_data", int'(rdata0), 1);

    // Randomised traffic on both ports
    fork
      for (int t = 0; t < 40; t++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        port_access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1, ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
      for (int t = 0; t < 40; t++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        port_access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1, ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
    join

    // Fixed priority: port 0 keeps winning while it requests
    @(negedge clk);
    p_req0 = 1'b1; p_req1 = 1'b1;
    begin
      int n0, bad;
      n0 = 0; bad = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (p_gnt1) bad++;
        if (p_gnt0) n0++;
      end
      check("prio_no_gnt1", bad, 0);
      check("prio_gnt0_count", n0, 4);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!p_gnt0 && n < 10);
    p_req0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!p_gnt1 && n < 10);
    check("prio_gnt1_delay", n, 3);
    p_req1 = 1'b0;

    repeat (6) @(negedge clk);
    check("gq_drained", gq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
